bf_coeff_ctrl: RTL and testbench

Coefficient controller for the CRPA BeamFormer datapath. It collects per-channel complex-weight writes into a shadow bank. It then commits the whole bank atomically on a frame strobe, so a beam update never applies a mixed old/new weight set. It drives the BeamFormer coeff bus and a validity flag that masks BeamFormer output for its pipeline latency after every coefficient swap and after reset.

---
 rtl/bf_coeff_ctrl.sv | 99 +++++++++
 tb/tb_bf_coeff_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bf_coeff_ctrl.sv
// Coefficient controller for the CRPA BeamFormer: collects channel weights in a shadow bank and
// commits the whole bank atomically on a frame strobe, masking out_valid while the pipeline flushes.
module bf_coeff_ctrl #(
    parameter  int NCH         = 4,
    parameter  int COEFF_WIDTH = 16,
    parameter  int BF_LATENCY  = 4,
    localparam int AW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [COEFF_WIDTH-1:0]     wr_data,
    input  logic                       commit_req,
    input  logic                       frame_stb,
    output logic [NCH*COEFF_WIDTH-1:0] coeff,
    output logic                       pending,
    output logic                       commit_ack,
    output logic                       out_valid,
    output logic                       wr_err
);
    localparam int            CW       = (BF_LATENCY > 0) ? $clog2(BF_LATENCY + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(BF_LATENCY);
    localparam logic [AW:0]   NCH_LIM  = (AW + 1)'(NCH);

    typedef enum logic [1:0] {IDLE, ARMED, FLUSH} state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [COEFF_WIDTH-1:0] shadow [NCH];
    logic                   addr_ok, wr_ok, load, ack_n, valid_n, err_n;

    // The shadow bank only accepts writes while idle, so it stays frozen from request to end of flush.
    assign addr_ok = ({1'b0, wr_addr} < NCH_LIM);
    assign wr_ok   = wr_en && (state == IDLE) && addr_ok;
    assign pending = (state != IDLE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        ack_n   = 1'b0;
        valid_n = out_valid;
        err_n   = wr_en && !wr_ok;
        case (state)
            IDLE: begin
                if (commit_req) state_n = ARMED;
            end
            ARMED: begin
                if (frame_stb) begin
                    load  = 1'b1;
                    ack_n = 1'b1;
                    if (BF_LATENCY == 0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = FLUSH;
                        cnt_n   = CNT_INIT;
                        valid_n = 1'b0;
                    end
                end
            end
            FLUSH: begin
                valid_n = 1'b0;
                if (cnt != '0) cnt_n = cnt - CW'(1);
                // Leaving on the count of one gives exactly BF_LATENCY masked cycles.
                if (cnt <= CW'(1)) begin
                    state_n = IDLE;
                    valid_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= FLUSH;
            cnt        <= CNT_INIT;
            coeff      <= '0;
            commit_ack <= 1'b0;
            out_valid  <= 1'b0;
            wr_err     <= 1'b0;
            // NOTE: the shadow bank is a small register file, so it is cleared with the rest of the state.
            for (int i = 0; i < NCH; i++) shadow[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
            state      <= state_n;
            cnt        <= cnt_n;
            commit_ack <= ack_n;
            out_valid  <= valid_n;
            wr_err     <= err_n;
            if (wr_ok) shadow[wr_addr] <= wr_data;
            if (load) begin
                for (int i = 0; i < NCH; i++) coeff[i*COEFF_WIDTH +: COEFF_WIDTH] <= shadow[i];
            end
        end
    end
endmodule

// File: tb/tb_bf_coeff_ctrl.sv
// Directed bench for bf_coeff_ctrl: a default build (NCH=4, BF_LATENCY=4) and a
// zero-latency build with NCH=5 so an out-of-range address is representable.
module tb_bf_coeff_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en, commit_req, frame_stb;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [63:0] coeff;
    logic        pending, commit_ack, out_valid, wr_err;

    logic        z_wr_en, z_commit_req, z_frame_stb;
    logic [2:0]  z_wr_addr;
    logic [15:0] z_wr_data;
    logic [79:0] z_coeff;
    logic        z_pending, z_commit_ack, z_out_valid, z_wr_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bf_coeff_ctrl #(.NCH(4), .COEFF_WIDTH(16), .BF_LATENCY(4)) u_dut (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit_req(commit_req), .frame_stb(frame_stb), .coeff(coeff), .pending(pending),
        .commit_ack(commit_ack), .out_valid(out_valid), .wr_err(wr_err)
    );

    bf_coeff_ctrl #(.NCH(5), .COEFF_WIDTH(16), .BF_LATENCY(0)) u_zlat (
        .clk(clk), .resetn(resetn), .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
        .commit_req(z_commit_req), .frame_stb(z_frame_stb), .coeff(z_coeff), .pending(z_pending),
        .commit_ack(z_commit_ack), .out_valid(z_out_valid), .wr_err(z_wr_err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; outputs are then sampled 1 time unit after the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    localparam logic [63:0] EXP1 = {16'h8000, 16'h7FFF, 16'hFF38, 16'h0064};
    localparam logic [63:0] EXP2 = {16'h8000, 16'h1234, 16'hFF38, 16'h0064};
    localparam logic [79:0] ZEXP = {16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 16'h0001};

    initial begin
        logic [15:0] vals [4];
        vals = '{16'h0064, 16'hFF38, 16'h7FFF, 16'h8000};

        resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit_req = 1'b0; frame_stb = 1'b0;
        z_wr_en = 1'b0; z_wr_addr = '0; z_wr_data = '0; z_commit_req = 1'b0; z_frame_stb = 1'b0;

        // Reset state
        tick(2);
        check("rst_coeff", coeff, 0);
        check("rst_pending", pending, 1);
        check("rst_valid", out_valid, 0);
        check("rst_ack", commit_ack, 0);
        check("rst_err", wr_err, 0);
        check("z_rst_valid", z_out_valid, 0);

        // Post-reset flush: out_valid low for 4 cycles after release
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rel_valid_low", out_valid, 0);
            check("rel_pending", pending, 1);
            tick(1);
        end
        check("rel_valid_high", out_valid, 1);
        check("rel_pending_low", pending, 0);
        check("z_rel_valid", z_out_valid, 1);

        // Load shadow bank, active bank must not move
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i); wr_data = vals[i];
            tick(1);
            check("idle_wr_no_err", wr_err, 0);
        end
        wr_en = 1'b0;
        check("shadow_not_active", coeff, 0);

        // Arm, then a rejected write and a second request while armed
        commit_req = 1'b1; tick(1); commit_req = 1'b0;
        check("armed_pending", pending, 1);
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'd7; tick(1); wr_en = 1'b0;
        check("armed_wr_err", wr_err, 1);
        commit_req = 1'b1; tick(1);
        check("wr_err_pulse", wr_err, 0);
        tick(1); commit_req = 1'b0;
        tick(1);
        check("armed_no_ack", commit_ack, 0);
        check("armed_coeff_hold", coeff, 0);

        // Frame strobe five cycles after the request commits the bank
        frame_stb = 1'b1; tick(1); frame_stb = 1'b0;
        check("commit_coeff", coeff, EXP1);
        check("commit_ack", commit_ack, 1);
        check("commit_valid_low", out_valid, 0);
        check("commit_pending", pending, 1);

        // Flush ignores writes, requests and strobes
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'd5; commit_req = 1'b1; frame_stb = 1'b1;
        tick(1);
        wr_en = 1'b0; commit_req = 1'b0; frame_stb = 1'b0;
        check("flush_wr_err", wr_err, 1);
        check("ack_pulse", commit_ack, 0);
        check("flush_valid_n2", out_valid, 0);
        tick(1);
        check("flush_valid_n3", out_valid, 0);
        tick(1);
        check("flush_valid_n4", out_valid, 0);
        tick(1);
        check("flush_valid_n5", out_valid, 1);
        check("flush_done_idle", pending, 0);
        check("flush_no_ack", commit_ack, 0);

        // Same-cycle write + request + strobe in IDLE: write kept, strobe not used
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'h1234; commit_req = 1'b1; frame_stb = 1'b1;
        tick(1);
        wr_en = 1'b0; commit_req = 1'b0; frame_stb = 1'b0;
        check("same_cyc_no_err", wr_err, 0);
        check("same_cyc_no_ack", commit_ack, 0);
        check("same_cyc_pending", pending, 1);
        check("same_cyc_coeff", coeff, EXP1);
        tick(4);
        commit_req = 1'b1; tick(1); commit_req = 1'b0;
        tick(4);
        check("wait_no_ack", commit_ack, 0);
        check("wait_coeff", coeff, EXP1);
        frame_stb = 1'b1; tick(1); frame_stb = 1'b0;
        check("late_commit_coeff", coeff, EXP2);
        check("late_commit_ack", commit_ack, 1);
        tick(4);
        check("late_valid", out_valid, 1);
        check("late_idle", pending, 0);
        frame_stb = 1'b1; tick(1); frame_stb = 1'b0;
        check("idle_stb_no_ack", commit_ack, 0);
        check("idle_stb_coeff", coeff, EXP2);

        // Reset while armed with a loaded shadow
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'h0BAD; tick(1); wr_en = 1'b0;
        commit_req = 1'b1; tick(1); commit_req = 1'b0;
        check("pre_rst_armed", pending, 1);
        resetn = 1'b0; tick(1);
        check("mid_rst_coeff", coeff, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ack", commit_ack, 0);
        resetn = 1'b1; tick(4);
        check("mid_rel_valid", out_valid, 1);
        check("mid_rel_idle", pending, 0);
        frame_stb = 1'b1; tick(1); frame_stb = 1'b0;
        check("dropped_commit_ack", commit_ack, 0);
        check("dropped_commit_coeff", coeff, 0);
        commit_req = 1'b1; tick(1); commit_req = 1'b0;
        frame_stb = 1'b1; tick(1); frame_stb = 1'b0;
        check("cleared_shadow_ack", commit_ack, 1);
        check("cleared_shadow_coeff", coeff, 0);
        tick(4);

        // Zero-latency, five-channel build
        check("z_idle_valid", z_out_valid, 1);
        check("z_idle_pending", z_pending, 0);
        z_wr_en = 1'b1; z_wr_addr = 3'd5; z_wr_data = 16'h5555; tick(1);
        check("z_oob_err", z_wr_err, 1);
        z_wr_addr = 3'd4; z_wr_data = 16'hABCD; tick(1);
        check("z_wr_no_err", z_wr_err, 0);
        z_wr_addr = 3'd0; z_wr_data = 16'h0001; tick(1);
        z_wr_addr = 3'd4; z_wr_data = 16'hBEEF; tick(1);
        z_wr_en = 1'b0;
        check("z_pre_commit_coeff", z_coeff, 0);
        z_commit_req = 1'b1; tick(1); z_commit_req = 1'b0;
        z_frame_stb = 1'b1; tick(1); z_frame_stb = 1'b0;
        check("z_commit_coeff", z_coeff, ZEXP);
        check("z_commit_ack", z_commit_ack, 1);
        check("z_commit_valid", z_out_valid, 1);
        check("z_commit_idle", z_pending, 0);
        tick(1);
        check("z_ack_pulse", z_commit_ack, 0);
        check("z_valid_stays", z_out_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
